// File: rtl/sme_feeder.sv
// Buffers one host record (string or pattern), checks its length, then streams it
// byte-per-cycle to the SME; pattern records hold off the host until sme_valid.
module sme_feeder #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_kind,
   input  logic       in_last,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       sme_valid,
   output logic       busy,
   output logic       err_len
);

   localparam int BUF_N = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
   localparam int AW    = (BUF_N > 1) ? $clog2(BUF_N) : 1;
   localparam int CW    = $clog2(BUF_N + 1);
   localparam logic [CW-1:0] STR_LIM = CW'(STR_MAX);
   localparam logic [CW-1:0] PAT_LIM = CW'(PAT_MAX);

   typedef enum logic [2:0] {IDLE, LOAD, DROP, STREAM, WAIT} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   rd_q, rd_d;
   logic            kind_q, kind_d;
   logic [7:0]      chardata_q, chardata_d;
   logic            isstring_q, isstring_d;
   logic            ispattern_q, ispattern_d;
   logic            err_len_q, err_len_d;
   logic            busy_q, busy_d;
   logic            in_ready_q, in_ready_d;
   logic [7:0]      buf_q [BUF_N];
   logic            wr_en;
   logic [AW-1:0]   wr_idx;
   logic            hs;
   logic [CW-1:0]   lim;

   always_comb begin
      hs          = in_valid & in_ready_q;
      lim         = kind_q ? PAT_LIM : STR_LIM;
      state_d     = state_q;
      count_d     = count_q;
      rd_d        = rd_q;
      kind_d      = kind_q;
      chardata_d  = '0;
      isstring_d  = 1'b0;
      ispattern_d = 1'b0;
      err_len_d   = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = count_q[AW-1:0];
      case (state_q)
         IDLE: begin
            if (hs) begin
               wr_en   = 1'b1;
               wr_idx  = '0;
               kind_d  = in_kind;
               count_d = CW'(1);
               if (in_last) begin
                  // single-byte record: the byte goes out straight from the input
                  state_d     = STREAM;
                  rd_d        = CW'(1);
                  chardata_d  = in_data;
                  isstring_d  = ~in_kind;
                  ispattern_d = in_kind;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (hs) begin
               if (count_q >= lim) begin
                  err_len_d = 1'b1;
                  count_d   = '0;
                  state_d   = in_last ? IDLE : DROP;
               end else begin
                  wr_en   = 1'b1;
                  count_d = count_q + CW'(1);
                  if (in_last) begin
                     state_d     = STREAM;
                     rd_d        = CW'(1);
                     chardata_d  = buf_q[0];
                     isstring_d  = ~kind_q;
                     ispattern_d = kind_q;
                  end
               end
            end
         end
         DROP: begin
            if (hs && in_last) state_d = IDLE;
         end
         STREAM: begin
            if (rd_q < count_q) begin
               chardata_d  = buf_q[rd_q[AW-1:0]];
               isstring_d  = ~kind_q;
               ispattern_d = kind_q;
               rd_d        = rd_q + CW'(1);
            end else begin
               count_d = '0;
               state_d = kind_q ? WAIT : IDLE;
            end
         end
         WAIT: begin
            if (sme_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == DROP);
      busy_d     = (state_d == LOAD) || (state_d == STREAM) || (state_d == WAIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rd_q        <= '0;
         kind_q      <= 1'b0;
         chardata_q  <= '0;
         isstring_q  <= 1'b0;
         ispattern_q <= 1'b0;
         err_len_q   <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_q        <= rd_d;
         kind_q      <= kind_d;
         chardata_q  <= chardata_d;
         isstring_q  <= isstring_d;
         ispattern_q <= ispattern_d;
         err_len_q   <= err_len_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) buf_q[wr_idx] <= in_data;
   end

   assign in_ready  = in_ready_q;
   assign chardata  = chardata_q;
   assign isstring  = isstring_q;
   assign ispattern = ispattern_q;
   assign busy      = busy_q;
   assign err_len   = err_len_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Bench for sme_feeder: directed records plus random records with host gaps,
// outputs compared against a record-level queue model.
module tb_sme_feeder;

   localparam int STR_MAX = 32;
   localparam int PAT_MAX = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_kind = 1'b0;
   logic       in_last = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       sme_auto = 1'b0;
   logic       sme_man = 1'b0;
   logic       sme_valid;
   logic       in_ready, isstring, ispattern, busy, err_len;
   logic [7:0] chardata;

   assign sme_valid = sme_auto | sme_man;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];
   int         exp_len_q[$];
   logic       exp_kind_q[$];
   int         mon_rem = 0;
   logic       mon_kind = 1'b0;
   logic [7:0] rec_q[$];
   logic       auto_en = 1'b0;

   sme_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_kind(in_kind), .in_last(in_last),
      .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .sme_valid(sme_valid), .busy(busy), .err_len(err_len)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Output monitor: every flagged byte must be the next one owed by the model.
   initial forever begin
      @(negedge clk);
      chk("both_flags", 32'(isstring & ispattern), 0);
      if (isstring | ispattern) begin
         if (mon_rem == 0) begin
            chk("out_expected", 32'(exp_len_q.size() != 0), 1);
            if (exp_len_q.size() != 0) begin
               mon_rem  = exp_len_q.pop_front();
               mon_kind = exp_kind_q.pop_front();
            end
         end
         if (mon_rem != 0) begin
            chk("out_byte", chardata, exp_q.pop_front());
            chk("out_kind", ispattern, mon_kind);
            mon_rem--;
         end
      end else begin
         chk("idle_data", chardata, 0);
         chk("stream_gap", mon_rem, 0);
         while (mon_rem > 0 && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            mon_rem--;
         end
         mon_rem = 0;
      end
   end

   // Auto SME responder: pulses sme_valid a random delay after a pattern ends.
   initial begin
      logic pat_prev = 1'b0;
      logic armed = 1'b0;
      int   cnt = 0;
      forever begin
         @(negedge clk);
         sme_auto = 1'b0;
         if (auto_en && !armed && pat_prev && !ispattern) begin
            armed = 1'b1;
            cnt   = $urandom_range(0, 4);
         end
         if (armed) begin
            if (cnt == 0) begin
               sme_auto = 1'b1;
               armed    = 1'b0;
            end else begin
               cnt--;
            end
         end
         pat_prev = ispattern;
      end
   end

   // Sends rec_q as one record; called and returns at a negedge.
   task automatic send_rec(input logic kind, input logic gaps);
      int   len = rec_q.size();
      int   lim = kind ? PAT_MAX : STR_MAX;
      logic ok  = (len <= lim);
      int   t;
      if (ok) begin
         foreach (rec_q[k]) exp_q.push_back(rec_q[k]);
         exp_len_q.push_back(len);
         exp_kind_q.push_back(kind);
      end
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               in_valid = 1'b0;
               @(negedge clk);
            end
         end
         in_valid = 1'b1;
         in_data  = rec_q[i];
         in_kind  = (i == 0) ? kind : 1'($urandom);
         in_last  = (i == len - 1);
         t = 0;
         while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
         end
         chk("hs_wait", in_ready, 1);
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
         chk("err_len", err_len, 32'(!ok && i == lim));
         chk("busy", busy, ok ? 1 : 32'(i < lim));
         chk("rdy", in_ready, 32'(!(ok && i == len - 1)));
         if (ok && i == len - 1) begin
            chk("lat_flag", kind ? ispattern : isstring, 1);
            chk("lat_byte", chardata, rec_q[0]);
         end
      end
   endtask

   task automatic rand_rec(input int len);
      rec_q.delete();
      for (int j = 0; j < len; j++) rec_q.push_back(8'($urandom));
   endtask

   initial begin
      int t;
      repeat (3) @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_str", isstring, 0);
      chk("rst_pat", ispattern, 0);
      chk("rst_data", chardata, 0);
      chk("rst_err", err_len, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("rel_ready", in_ready, 1);
      chk("rel_busy", busy, 0);

      rec_q = {8'h61, 8'h62, 8'h63};
      send_rec(1'b0, 1'b0);
      @(negedge clk);
      chk("abc_b1", chardata, 8'h62);
      @(negedge clk);
      chk("abc_b2", chardata, 8'h63);
      chk("abc_b2_flag", isstring, 1);
      @(negedge clk);
      chk("abc_end_flag", isstring, 0);
      chk("abc_end_busy", busy, 0);
      chk("abc_end_rdy", in_ready, 1);

      rec_q = {8'h61, 8'h62};
      send_rec(1'b1, 1'b0);
      @(negedge clk);
      chk("ab_b1", chardata, 8'h62);
      chk("ab_b1_flag", ispattern, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("ab_wait_rdy", in_ready, 0);
         chk("ab_wait_busy", busy, 1);
      end
      sme_man = 1'b1;
      @(negedge clk);
      sme_man = 1'b0;
      chk("ab_rel_rdy", in_ready, 1);
      chk("ab_rel_busy", busy, 0);
      auto_en = 1'b1;

      rand_rec(STR_MAX);
      send_rec(1'b0, 1'b0);
      rand_rec(STR_MAX + 1);
      send_rec(1'b0, 1'b0);
      rec_q = {8'h61, 8'h62, 8'h63};
      send_rec(1'b0, 1'b0);
      rand_rec(PAT_MAX + 1);
      send_rec(1'b1, 1'b1);
      rand_rec(PAT_MAX + 4);
      send_rec(1'b1, 1'b1);
      rand_rec(PAT_MAX);
      send_rec(1'b1, 1'b1);

      rec_q = {8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
      send_rec(1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("hello_b1", chardata, 8'h65);
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      exp_len_q.delete();
      exp_kind_q.delete();
      mon_rem = 0;
      @(negedge clk);
      chk("abort_str", isstring, 0);
      chk("abort_data", chardata, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rdy", in_ready, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_rel_rdy", in_ready, 1);
      rec_q = {8'h78};
      send_rec(1'b0, 1'b0);

      for (int r = 0; r < 40; r++) begin
         logic k = 1'($urandom);
         int   lim = k ? PAT_MAX : STR_MAX;
         int   len = ($urandom_range(0, 3) == 0) ? lim + $urandom_range(0, 1)
                                                 : $urandom_range(1, lim + 2);
         rand_rec(len);
         send_rec(k, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      chk("drain_rem", mon_rem, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sme_feeder.md
SME_FEEDER -- requirements
Module: sme_feeder

Interface
REQ-001 The block SHALL use clock clk and reset reset, which is synchronous and active-high.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  host byte valid
- in_ready  out  1  feeder can accept a byte
- in_data  in  8  host ASCII byte
- in_kind  in  1  record type, 0=string, 1=pattern; sampled on first byte of record
- in_last  in  1  final byte of record
- chardata  out  8  byte to SME
- isstring  out  1  chardata is a string byte
- ispattern  out  1  chardata is a pattern byte
- sme_valid  in  1  SME result-valid pulse
- busy  out  1  record held or in flight
- err_len  out  1  one-cycle pulse, record length violation
REQ-003 Parameters SHALL be, one per line (name, default, meaning):
- STR_MAX, 32, max string length in bytes
- PAT_MAX, 8, max pattern length in bytes

Function
REQ-004 Handshake SHALL occur on any rising edge with in_valid=1 and in_ready=1; no byte is taken otherwise.
REQ-005 FSM states SHALL be IDLE, LOAD, DROP, STREAM, WAIT; reset state IDLE.
REQ-006 in_ready SHALL be 1 in IDLE, LOAD, DROP and 0 in STREAM, WAIT.
REQ-007 IDLE: on handshake, store byte at buffer index 0, latch in_kind, count=1; go to STREAM if in_last, else LOAD.
REQ-008 LOAD: on each handshake, store byte at index count, count+1; in_kind on non-first bytes SHALL be ignored.
REQ-009 LOAD: handshake with in_last and resulting length <= limit (STR_MAX string, PAT_MAX pattern) SHALL go to STREAM next cycle.
REQ-010 A handshake that would make length exceed the limit SHALL pulse err_len for one cycle, discard the record, go to DROP (or IDLE if that byte has in_last).
REQ-011 DROP: accept and discard bytes; handshake with in_last SHALL return to IDLE; nothing is driven to SME.
REQ-012 STREAM: emit buffer[0..count-1], one byte per cycle, no gaps, with isstring=1 (string) or ispattern=1 (pattern), the other flag 0.
REQ-013 First streamed byte SHALL appear on outputs the cycle after the in_last handshake edge (latency 1).
REQ-014 After the last byte: string record returns to IDLE; pattern record goes to WAIT; both flags 0 the following cycle.
REQ-015 WAIT: remain until sme_valid=1 is sampled, then go to IDLE; sme_valid outside WAIT SHALL be ignored.
REQ-016 When neither flag is high, chardata SHALL be 8'h00.
REQ-017 isstring and ispattern SHALL never be 1 in the same cycle.
REQ-018 busy SHALL be 1 in LOAD, STREAM, WAIT; 0 in IDLE and DROP.
REQ-019 All outputs SHALL be driven from registers.
REQ-020 Length-1 records SHALL stream one byte; records of exactly STR_MAX/PAT_MAX bytes SHALL be accepted.
REQ-021 Idle cycles with both flags 0 between records are permitted; record order SHALL be preserved.

Reset
REQ-022 reset=1 SHALL force IDLE, count=0, chardata=0, isstring=0, ispattern=0, err_len=0, busy=0, in_ready=0 while asserted; in_ready=1 the cycle after release.
REQ-023 reset asserted in any state (including mid-STREAM or WAIT) SHALL abort the record; no further bytes of it are emitted after reset.
REQ-024 Buffer contents need no reset; no stale byte SHALL ever be emitted.

Verification
REQ-025 String "abc" (kind 0, last on 'c') -> next 3 cycles chardata 61,62,63 with isstring=1, then flags 0, busy 0, in_ready 1.
REQ-026 Pattern "ab" (kind 1) -> 61,62 with ispattern=1; in_ready stays 0 until sme_valid pulse held 5 cycles later, then in_ready=1 next cycle.
REQ-027 32-byte string accepted and streamed contiguously over 32 cycles; 33-byte string -> err_len pulse on 33rd handshake, no isstring, next record streams normally.
REQ-028 9-byte pattern -> err_len on 9th byte, DROP until in_last, no ispattern ever asserted; in_valid toggling randomly still yields exact byte order on valid records.
REQ-029 reset asserted on 2nd streamed byte of "hello" -> all outputs 0 next cycle, no remaining bytes emitted, fresh string "x" afterwards streams 78 with isstring=1.
